// File: rtl/bka_stream_accumulator.sv
// Brent-Kung prefix adder: N-bit sum with carry-in and carry-out.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module brent_kung_paralell_prefixAdder #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int TOP = (N > 1) ? 2 ** ($clog2(N) - 1) : 1;

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N-1:0] c;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = g;
        pp = p;
        // Folding cin into bit 0 makes every group generate a true carry-out.
        gg[0] = g[0] | (p[0] & cin);

        for (int d = 1; d < N; d = d * 2) begin
            for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end

        for (int d = TOP; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
            end
        end

        c[0] = cin;
        for (int i = 1; i < N; i++) begin
            c[i] = gg[i-1];
        end
        sum  = p ^ c;
        cout = gg[N-1];
    end

endmodule

// Frame accumulator: adds/subtracts operand beats, holds result until consumed.
// Latency: beat result on acc at the accepting edge; out_valid from the in_last edge.
// Backpressure: in_ready low while a result waits in HOLD for out_ready.
module bka_stream_accumulator #(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_beats
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     acc;
    logic             ovf;
    logic [CNT_W-1:0] beats;

    logic [N-1:0]     b_op;
    logic [N-1:0]     add_sum;
    logic             add_cout;
    logic             beat_ovf;

    assign b_op = in_sub ? ~in_data : in_data;

    brent_kung_paralell_prefixAdder #(.N(N)) u_adder (
        .a    (acc),
        .b    (b_op),
        .cin  (in_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Subtraction is a + ~b + 1, so a missing carry-out means a borrow.
    assign beat_ovf = in_sub ? ~add_cout : add_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            beats <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc   <= add_sum;
                        ovf   <= ovf | beat_ovf;
                        if (beats != {CNT_W{1'b1}}) begin
                            beats <= beats + 1'b1;
                        end
                        state <= in_last ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        beats <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_beats = beats;

endmodule

// File: doc/bka_stream_accumulator.md
BKA_STREAM_ACCUMULATOR -- requirements
Module: bka_stream_accumulator

Interface
REQ-001 SHALL have parameter N, default 64, operand/accumulator width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of the beat counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-007 SHALL have port in_data  input  N  unsigned operand.
REQ-008 SHALL have port in_sub  input  1  1 = subtract in_data, 0 = add in_data.
REQ-009 SHALL have port in_last  input  1  beat closes the current frame.
REQ-010 SHALL have port out_valid  output  1  frame result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port out_sum  output  N  accumulated result, modulo 2^N.
REQ-013 SHALL have port out_ovf  output  1  sticky unsigned overflow/underflow flag for the frame.
REQ-014 SHALL have port out_beats  output  CNT_W  number of beats accepted in the frame, saturating.

Function
REQ-015 SHALL instantiate brent_kung_paralell_prefixAdder #(N) as the only adder: a = acc, b = in_sub ? ~in_data : in_data, cin = in_sub.
REQ-016 SHALL implement FSM states IDLE, ACCUM, HOLD; a beat is accepted when in_valid && in_ready at a rising edge.
REQ-017 SHALL drive in_ready = 1 in IDLE and ACCUM and 0 in HOLD; out_valid = 1 only in HOLD.
REQ-018 IDLE: acc, ovf and beat count are zero; accepted beat -> acc <= adder sum, beats <= 1, next state ACCUM, or HOLD if in_last.
REQ-019 ACCUM: each accepted beat -> acc <= adder sum, beats <= beats+1 (saturate at 2^CNT_W-1, no wrap); in_last -> HOLD; no beat -> hold all state.
REQ-020 Overflow: add beat with adder cout = 1, or sub beat with adder cout = 0 (borrow), SHALL set ovf; ovf stays set until the frame is consumed.
REQ-021 Latency: result of the beat accepted at edge k SHALL be on acc at edge k; with in_last, out_valid SHALL be high from edge k until the handshake.
REQ-022 HOLD: out_sum, out_ovf, out_beats SHALL be stable while out_valid && !out_ready; in_data ignored.
REQ-023 HOLD with out_ready = 1 at an edge -> acc, ovf, beats cleared, next state IDLE; first beat of next frame accepted no earlier than the following edge.
REQ-024 out_sum/out_ovf/out_beats SHALL reflect live acc/ovf/beats in all states; consumers sample only when out_valid = 1.
REQ-025 Sum arithmetic SHALL be modulo 2^N; a first beat with in_sub = 1 and in_data != 0 SHALL underflow and set ovf.
REQ-026 in_sub and in_last SHALL be sampled only on accepted beats; X on them when not accepted SHALL not affect state.

Reset
REQ-027 rst = 1 SHALL immediately (asynchronously) force state IDLE, acc = 0, ovf = 0, beats = 0, so out_valid = 0, in_ready = 1, out_sum = 0.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or pending result; no output handshake occurs for it.
REQ-029 After rst deasserts, the first rising edge SHALL be able to accept a beat.

Verification
REQ-030 Beats add 1, add 1 (last) -> out_valid next cycle, out_sum = 2, out_ovf = 0, out_beats = 2.
REQ-031 Beats add 64'hFFFF_FFFF_FFFF_FFFF, add 1 (last) -> out_sum = 0, out_ovf = 1, out_beats = 2.
REQ-032 Beats add 15, sub 20 (last) -> out_sum = 64'hFFFF_FFFF_FFFF_FFFB, out_ovf = 1; frame add 20, sub 15 (last) -> out_sum = 5, out_ovf = 0.
REQ-033 Single beat add 170 with in_last, out_ready held 0 for 5 cycles -> out_valid and out_sum = 170 stable, in_ready = 0, offered beats not accepted; out_ready = 1 -> next cycle IDLE, in_ready = 1, out_sum = 0.
REQ-034 Frame add 240, add 15 with in_valid gaps between beats, then add 1 (last) -> out_sum = 256, out_beats = 3, gaps change nothing.
REQ-035 rst pulsed after two beats of a frame and again while in HOLD -> out_valid = 0, out_sum = 0, out_beats = 0 immediately; next frame add 7 (last) -> out_sum = 7, out_beats = 1.
